uart_tx_arb: RTL and testbench

UART_TX_ARB -- requirements
Module: uart_tx_arb

---
 rtl/uart_tx_arb_pkg.sv | 65 ++++++
 rtl/uart_tx_arb_rr_arb2.sv | 38 +++
 rtl/uart_tx_arb.sv | 159 +++++++++++++++
 tb/tb_uart_tx_arb.sv | 465 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_arb_pkg.sv
// Shared UART register map, FSM state encoding and bus-request helpers for uart_tx_arb.
// The INIT_BAUD state only exists when UART_ARB_BAUD_INIT_EN is defined.
package uart_tx_arb_pkg;

    // Register offsets within the UART block; the UART decodes the same constants.
    localparam logic [31:0] UART_CTRL_OFF   = 32'h0000_0000;
    localparam logic [31:0] UART_STATUS_OFF = 32'h0000_0004;
    localparam logic [31:0] UART_BAUD_OFF   = 32'h0000_0008;
    localparam logic [31:0] UART_TXDATA_OFF = 32'h0000_000C;

    localparam logic [31:0] UART_CTRL_ENABLE        = 32'h0000_0001;
    localparam int          UART_STATUS_TX_BUSY_BIT = 0;

    typedef enum logic [2:0] {
`ifdef UART_ARB_BAUD_INIT_EN
        INIT_BAUD,
`endif
        INIT_CTRL,
        INIT_RSP,
        IDLE,
        POLL,
        POLL_RSP,
        WRITE,
        WRITE_RSP
    } arb_state_t;

`ifdef UART_ARB_BAUD_INIT_EN
    localparam arb_state_t RESET_STATE = INIT_BAUD;
`else
    localparam arb_state_t RESET_STATE = INIT_CTRL;
`endif

    typedef struct packed {
        logic        valid;
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  sel;
    } bus_req_t;

    localparam bus_req_t BUS_REQ_NONE = '0;

    function automatic bus_req_t bus_write(input logic [31:0] addr,
                                           input logic [31:0] data,
                                           input logic [3:0]  sel);
        bus_req_t r;
        r.valid = 1'b1;
        r.we    = 1'b1;
        r.addr  = addr;
        r.data  = data;
        r.sel   = sel;
        return r;
    endfunction

    function automatic bus_req_t bus_read(input logic [31:0] addr);
        bus_req_t r;
        r.valid = 1'b1;
        r.we    = 1'b0;
        r.addr  = addr;
        r.data  = '0;
        r.sel   = 4'b1111;
        return r;
    endfunction

endpackage

// File: rtl/uart_tx_arb_rr_arb2.sv
// rr_arb2: two-way round-robin arbiter with a last-grant register and one-hot grant.
// The register resets to requester 1 so requester 0 wins the first tie.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en_i,
    input  logic [1:0] req_i,
    output logic [1:0] gnt_o
);

    logic last_q, last_d;

    // NOTE: every signal assigned in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        gnt_o  = 2'b00;
        last_d = last_q;
        if (en_i) begin
            if (req_i == 2'b11) begin
                gnt_o = last_q ? 2'b01 : 2'b10;
            end else begin
                gnt_o = req_i;
            end
            if (|req_i) begin
                last_d = gnt_o[1];
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/uart_tx_arb.sv
// uart_tx_arb: arbitrates bytes from two requesters onto a memory-mapped UART (poll STATUS, write TXDATA).
// Define UART_ARB_BAUD_INIT_EN to program BAUD with BAUD_DIV before the CTRL enable write.
module uart_tx_arb
    import uart_tx_arb_pkg::*;
#(
    parameter logic [31:0] UART_BASE = 32'h3000_0000,
    parameter logic [15:0] BAUD_DIV  = 16'd434
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        req0_valid_i,
    input  logic [7:0]  req0_data_i,
    output logic        req0_ready_o,
    input  logic        req1_valid_i,
    input  logic [7:0]  req1_data_i,
    output logic        req1_ready_o,

    output logic [31:0] m_addr_o,
    output logic [31:0] m_data_o,
    output logic [3:0]  m_sel_o,
    output logic        m_we_o,
    output logic        m_req_valid_o,
    input  logic        m_req_ready_i,
    input  logic        m_rsp_valid_i,
    output logic        m_rsp_ready_o,
    input  logic [31:0] m_data_i,

    output logic        busy_o
);

    arb_state_t  state_q, state_d;
    logic [7:0]  byte_q, byte_d;
    logic        baud_pend_q, baud_pend_d;
    bus_req_t    bus_req;
    logic        rsp_ready;
    logic        arb_en;
    logic [1:0]  gnt;

    // Only STATUS.tx_busy matters; the rest of the read word is ignored.
    logic unused_rdata;
    assign unused_rdata = ^m_data_i[31:1];
`ifndef UART_ARB_BAUD_INIT_EN
    logic [15:0] unused_baud_div;
    assign unused_baud_div = BAUD_DIV;
`endif

    assign arb_en = rst_n && (state_q == IDLE);

    rr_arb2 u_rr_arb2 (
        .clk   (clk),
        .rst_n (rst_n),
        .en_i  (arb_en),
        .req_i ({req1_valid_i, req0_valid_i}),
        .gnt_o (gnt)
    );

    always_comb begin
        state_d     = state_q;
        byte_d      = byte_q;
        baud_pend_d = baud_pend_q;
        bus_req     = BUS_REQ_NONE;
        rsp_ready   = 1'b0;

        case (state_q)
`ifdef UART_ARB_BAUD_INIT_EN
            INIT_BAUD: begin
                bus_req = bus_write(UART_BASE + UART_BAUD_OFF, {16'h0, BAUD_DIV}, 4'b0011);
                if (m_req_ready_i) begin
                    state_d     = INIT_CTRL;
                    baud_pend_d = 1'b1;
                end
            end
`endif
            INIT_CTRL: begin
                // The BAUD response is drained here before the enable write goes out.
                if (baud_pend_q) begin
                    rsp_ready = 1'b1;
                    if (m_rsp_valid_i) begin
                        baud_pend_d = 1'b0;
                    end
                end else begin
                    bus_req = bus_write(UART_BASE + UART_CTRL_OFF, UART_CTRL_ENABLE, 4'b0001);
                    if (m_req_ready_i) begin
                        state_d = INIT_RSP;
                    end
                end
            end
            INIT_RSP: begin
                rsp_ready = 1'b1;
                if (m_rsp_valid_i) begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                if (|gnt) begin
                    byte_d  = gnt[1] ? req1_data_i : req0_data_i;
                    state_d = POLL;
                end
            end
            POLL: begin
                bus_req = bus_read(UART_BASE + UART_STATUS_OFF);
                if (m_req_ready_i) begin
                    state_d = POLL_RSP;
                end
            end
            POLL_RSP: begin
                rsp_ready = 1'b1;
                if (m_rsp_valid_i) begin
                    state_d = m_data_i[UART_STATUS_TX_BUSY_BIT] ? POLL : WRITE;
                end
            end
            WRITE: begin
                bus_req = bus_write(UART_BASE + UART_TXDATA_OFF, {24'h0, byte_q}, 4'b0001);
                if (m_req_ready_i) begin
                    state_d = WRITE_RSP;
                end
            end
            WRITE_RSP: begin
                rsp_ready = 1'b1;
                if (m_rsp_valid_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = RESET_STATE;
            end
        endcase

        // Outputs are forced low while reset is held, not just after the first edge.
        if (!rst_n) begin
            bus_req   = BUS_REQ_NONE;
            rsp_ready = 1'b0;
        end
    end

    assign m_req_valid_o = bus_req.valid;
    assign m_we_o        = bus_req.we;
    assign m_addr_o      = bus_req.addr;
    assign m_data_o      = bus_req.data;
    assign m_sel_o       = bus_req.sel;
    assign m_rsp_ready_o = rsp_ready;
    assign req0_ready_o  = gnt[0];
    assign req1_ready_o  = gnt[1];
    assign busy_o        = rst_n && (state_q != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RESET_STATE;
            byte_q      <= '0;
            baud_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            byte_q      <= byte_d;
            baud_pend_q <= baud_pend_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_arb.sv
// Self-checking bench for uart_tx_arb: behavioural UART slave, queue-based requesters and
// a reference model of the expected bus traffic, round-robin order and byte delivery.
module tb_uart_tx_arb;

    localparam logic [31:0] BASE      = 32'h3000_0000;
    localparam logic [31:0] A_CTRL    = BASE + 32'h0;
    localparam logic [31:0] A_STATUS  = BASE + 32'h4;
    localparam logic [31:0] A_BAUD    = BASE + 32'h8;
    localparam logic [31:0] A_TXDATA  = BASE + 32'hC;
`ifdef UART_ARB_BAUD_INIT_EN
    localparam int INIT_N = 2;
`else
    localparam int INIT_N = 1;
`endif

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  sel;
    } txn_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0_valid_i = 1'b0, req1_valid_i = 1'b0;
    logic [7:0]  req0_data_i = '0, req1_data_i = '0;
    logic        req0_ready_o, req1_ready_o;
    logic [31:0] m_addr_o, m_data_o;
    logic [3:0]  m_sel_o;
    logic        m_we_o, m_req_valid_o, m_rsp_ready_o, busy_o;
    logic        m_req_ready_i = 1'b1;
    logic        m_rsp_valid_i = 1'b0;
    logic [31:0] m_data_i = '0;

    uart_tx_arb dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req0_valid_i  (req0_valid_i),
        .req0_data_i   (req0_data_i),
        .req0_ready_o  (req0_ready_o),
        .req1_valid_i  (req1_valid_i),
        .req1_data_i   (req1_data_i),
        .req1_ready_o  (req1_ready_o),
        .m_addr_o      (m_addr_o),
        .m_data_o      (m_data_o),
        .m_sel_o       (m_sel_o),
        .m_we_o        (m_we_o),
        .m_req_valid_o (m_req_valid_o),
        .m_req_ready_i (m_req_ready_i),
        .m_rsp_valid_i (m_rsp_valid_i),
        .m_rsp_ready_o (m_rsp_ready_o),
        .m_data_i      (m_data_i),
        .busy_o        (busy_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Bench state shared between the UART model, requesters and monitor.
    txn_t       log_q[$];
    logic [7:0] src0[$], src1[$];
    logic [7:0] exp_q[$];
    int         busy_left = 0, stall_left = 0, stall_seen = 0;
    bit         rand_busy = 0, rand_stall = 0;
    bit         s_req = 0, s_rsp = 0, s_acc0 = 0, s_acc1 = 0;
    bit         rsp_is_read = 0, last_status_busy = 0;
    bit         prev_stalled = 0;
    txn_t       prev_txn = '0;
    int         tb_last = 1;
    int         last_acc_cyc = 0, last_wr_cyc = 0;

    function automatic txn_t mk(input logic we, input logic [31:0] addr,
                                input logic [31:0] data, input logic [3:0] sel);
        txn_t t;
        t.we = we; t.addr = addr; t.data = data; t.sel = sel;
        return t;
    endfunction

    always @(posedge clk) cyc++;

    // Monitor: samples at the falling edge what the next rising edge will commit.
    always @(negedge clk) begin
        txn_t cur;
        cur = mk(m_we_o, m_addr_o, m_data_o, m_sel_o);
        if (!rst_n) begin
            s_req = 0; s_rsp = 0; s_acc0 = 0; s_acc1 = 0;
            prev_stalled = 0; last_status_busy = 0; tb_last = 1;
        end else begin
            s_req  = m_req_valid_o && m_req_ready_i;
            s_rsp  = m_rsp_valid_i && m_rsp_ready_o;
            s_acc0 = req0_valid_i && req0_ready_o;
            s_acc1 = req1_valid_i && req1_ready_o;

            checks++;
            if (!m_req_valid_o && (cur !== '0)) begin
                errors++;
                $display("FAIL idle_bus_zero: got %h, expected 0 at cycle %0d", cur, cyc);
            end
            checks++;
            if ((req0_ready_o && req1_ready_o) || ((req0_ready_o || req1_ready_o) && busy_o)) begin
                errors++;
                $display("FAIL ready_onehot_idle: got r0=%b r1=%b busy=%b at cycle %0d",
                         req0_ready_o, req1_ready_o, busy_o, cyc);
            end
            if (prev_stalled) begin
                checks++;
                if (!m_req_valid_o || cur !== prev_txn) begin
                    errors++;
                    $display("FAIL req_stable: got valid=%b %h, expected %h", m_req_valid_o, cur, prev_txn);
                end
            end
            prev_stalled = m_req_valid_o && !m_req_ready_i;
            prev_txn     = cur;
            if (m_req_valid_o && !m_req_ready_i && m_we_o && m_addr_o == A_TXDATA) stall_seen++;

            if (req0_valid_i && req1_valid_i && (s_acc0 || s_acc1)) begin
                checks++;
                if ((s_acc0 ? 0 : 1) == tb_last) begin
                    errors++;
                    $display("FAIL round_robin: got grant %0d, expected %0d", s_acc0 ? 0 : 1, 1 - tb_last);
                end
            end
            if (s_acc0) begin exp_q.push_back(req0_data_i); tb_last = 0; last_acc_cyc = cyc; end
            if (s_acc1) begin exp_q.push_back(req1_data_i); tb_last = 1; last_acc_cyc = cyc; end

            if (s_rsp && rsp_is_read) last_status_busy = m_data_i[0];
            if (s_req) begin
                log_q.push_back(cur);
                if (cur.we && cur.addr == A_TXDATA) begin
                    last_wr_cyc = cyc;
                    checks++;
                    if (last_status_busy) begin
                        errors++;
                        $display("FAIL write_after_busy: got TXDATA write, expected STATUS idle first");
                    end
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL txdata_byte: got unexpected write %h, expected none", cur.data);
                    end else begin
                        if (cur.data !== {24'h0, exp_q[0]} || cur.sel !== 4'b0001) begin
                            errors++;
                            $display("FAIL txdata_byte: got data=%h sel=%h, expected data=%h sel=1",
                                     cur.data, cur.sel, {24'h0, exp_q[0]});
                        end
                        void'(exp_q.pop_front());
                    end
                end
            end
        end
    end

    // UART slave model: one-cycle response, optional busy STATUS and request back-pressure.
    always @(posedge clk) begin
        logic [31:0] r;
        logic        b;
        #1;
        if (!rst_n) begin
            m_rsp_valid_i = 1'b0;
            m_req_ready_i = 1'b1;
            m_data_i      = '0;
        end else begin
            if (s_rsp) begin
                m_rsp_valid_i = 1'b0;
                m_data_i      = '0;
            end
            if (s_req) begin
                rsp_is_read = !prev_txn.we;
                r = $urandom;
                if (!prev_txn.we) begin
                    b = (busy_left > 0) || (rand_busy && $urandom_range(0, 2) == 0);
                    if (busy_left > 0) busy_left--;
                    m_data_i = {r[31:1], b};
                end else begin
                    m_data_i = '0;
                end
                m_rsp_valid_i = 1'b1;
            end
            if (stall_left > 0 && m_req_valid_o && m_we_o && m_addr_o == A_TXDATA) begin
                m_req_ready_i = 1'b0;
                stall_left--;
            end else if (rand_stall) begin
                m_req_ready_i = ($urandom_range(0, 3) != 0);
            end else begin
                m_req_ready_i = 1'b1;
            end
        end
    end

    // Requesters: present the head of their queue, drop it once accepted.
    always @(posedge clk) begin
        #1;
        if (s_acc0 && src0.size() > 0) void'(src0.pop_front());
        if (s_acc1 && src1.size() > 0) void'(src1.pop_front());
        req0_valid_i = (src0.size() > 0);
        req0_data_i  = (src0.size() > 0) ? src0[0] : 8'h00;
        req1_valid_i = (src1.size() > 0);
        req1_data_i  = (src1.size() > 0) ? src1[0] : 8'h00;
    end

    task automatic wait_log(input int n, input int budget, input string name);
        int k = 0;
        while (log_q.size() < n && k < budget) begin
            @(posedge clk);
            k++;
        end
        checks++;
        if (log_q.size() < n) begin
            errors++;
            $display("FAIL %s: timeout, got %0d transactions, expected %0d", name, log_q.size(), n);
        end
    endtask

    task automatic check_init(input string name);
        wait_log(INIT_N, 40, name);
`ifdef UART_ARB_BAUD_INIT_EN
        checks++;
        if (log_q[0] !== mk(1'b1, A_BAUD, 32'h0000_01B2, 4'b0011)) begin
            errors++;
            $display("FAIL %s_baud: got %h, expected %h", name, log_q[0], mk(1'b1, A_BAUD, 32'h1B2, 4'b0011));
        end
`endif
        checks++;
        if (log_q[INIT_N-1] !== mk(1'b1, A_CTRL, 32'h1, 4'b0001)) begin
            errors++;
            $display("FAIL %s_ctrl: got %h, expected %h", name, log_q[INIT_N-1], mk(1'b1, A_CTRL, 32'h1, 4'b0001));
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({m_req_valid_o, m_we_o, m_sel_o, m_addr_o, m_data_o, m_rsp_ready_o,
             req0_ready_o, req1_ready_o, busy_o} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got addr=%h data=%h valid=%b busy=%b, expected all 0",
                     m_addr_o, m_data_o, m_req_valid_o, busy_o);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (busy_o !== 1'b1) begin
            errors++;
            $display("FAIL init_busy: got %b, expected 1", busy_o);
        end
        check_init("init");
        repeat (10) @(posedge clk);
        #1;
        checks++;
        if (busy_o !== 1'b0 || log_q.size() != INIT_N) begin
            errors++;
            $display("FAIL init_done: got busy=%b txns=%0d, expected busy=0 txns=%0d", busy_o, log_q.size(), INIT_N);
        end
    endtask

    task automatic test_single();
        log_q.delete();
        busy_left = 0;
        @(negedge clk);
        src0.push_back(8'h55);
        wait_log(2, 40, "single");
        checks++;
        if ({log_q[0].we, log_q[0].addr} !== {1'b0, A_STATUS}) begin
            errors++;
            $display("FAIL single_poll: got we=%b addr=%h, expected we=0 addr=%h", log_q[0].we, log_q[0].addr, A_STATUS);
        end
        checks++;
        if (log_q[1] !== mk(1'b1, A_TXDATA, 32'h55, 4'b0001)) begin
            errors++;
            $display("FAIL single_write: got %h, expected %h", log_q[1], mk(1'b1, A_TXDATA, 32'h55, 4'b0001));
        end
        checks++;
        if (last_wr_cyc - last_acc_cyc != 3) begin
            errors++;
            $display("FAIL single_latency: got %0d, expected 3", last_wr_cyc - last_acc_cyc);
        end
        repeat (10) @(posedge clk);
        #1;
        checks++;
        if (log_q.size() != 2 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL single_quiet: got txns=%0d busy=%b, expected txns=2 busy=0", log_q.size(), busy_o);
        end
    endtask

    task automatic test_busy_poll();
        logic [7:0] b;
        log_q.delete();
        b = 8'($urandom);
        @(negedge clk);
        busy_left = 3;
        src1.push_back(b);
        wait_log(5, 60, "busy_poll");
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({log_q[i].we, log_q[i].addr} !== {1'b0, A_STATUS}) begin
                errors++;
                $display("FAIL busy_poll_read%0d: got we=%b addr=%h, expected STATUS read", i, log_q[i].we, log_q[i].addr);
            end
        end
        checks++;
        if (log_q[4] !== mk(1'b1, A_TXDATA, {24'h0, b}, 4'b0001)) begin
            errors++;
            $display("FAIL busy_poll_write: got %h, expected %h", log_q[4], mk(1'b1, A_TXDATA, {24'h0, b}, 4'b0001));
        end
        repeat (10) @(posedge clk);
        checks++;
        if (log_q.size() != 5) begin
            errors++;
            $display("FAIL busy_poll_count: got %0d, expected 5", log_q.size());
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] wr[$];
        int first;
        log_q.delete();
        @(negedge clk);
        first = (tb_last == 1) ? 0 : 1;
        for (int i = 0; i < 3; i++) begin
            src0.push_back(8'hA0);
            src1.push_back(8'hB1);
        end
        wait_log(12, 200, "back_to_back");
        foreach (log_q[i]) if (log_q[i].we && log_q[i].addr == A_TXDATA) wr.push_back(log_q[i].data[7:0]);
        checks++;
        if (wr.size() != 6) begin
            errors++;
            $display("FAIL b2b_count: got %0d, expected 6", wr.size());
        end
        for (int i = 0; i < 6 && i < wr.size(); i++) begin
            checks++;
            if (wr[i] !== ((((i + first) % 2) == 0) ? 8'hA0 : 8'hB1)) begin
                errors++;
                $display("FAIL b2b_order%0d: got %h, expected %h", i, wr[i],
                         (((i + first) % 2) == 0) ? 8'hA0 : 8'hB1);
            end
        end
    endtask

    task automatic test_stall();
        logic [7:0] b;
        log_q.delete();
        b = 8'($urandom);
        @(negedge clk);
        stall_seen = 0;
        stall_left = 5;
        src0.push_back(b);
        wait_log(2, 60, "stall");
        checks++;
        if (log_q[1] !== mk(1'b1, A_TXDATA, {24'h0, b}, 4'b0001)) begin
            errors++;
            $display("FAIL stall_write: got %h, expected %h", log_q[1], mk(1'b1, A_TXDATA, {24'h0, b}, 4'b0001));
        end
        checks++;
        if (stall_seen != 5) begin
            errors++;
            $display("FAIL stall_cycles: got %0d, expected 5", stall_seen);
        end
        repeat (10) @(posedge clk);
        checks++;
        if (log_q.size() != 2) begin
            errors++;
            $display("FAIL stall_count: got %0d, expected 2", log_q.size());
        end
    endtask

    task automatic test_random();
        int n_wr = 0;
        int k = 0;
        log_q.delete();
        rand_busy  = 1;
        rand_stall = 1;
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            repeat ($urandom_range(0, 6)) @(negedge clk);
            if ($urandom_range(0, 1) == 1) src1.push_back(8'($urandom));
            else                           src0.push_back(8'($urandom));
        end
        while ((src0.size() + src1.size() + exp_q.size() > 0 || busy_o) && k < 4000) begin
            @(posedge clk);
            #2;
            k++;
        end
        rand_busy  = 0;
        rand_stall = 0;
        checks++;
        if (src0.size() + src1.size() + exp_q.size() != 0 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL random_drain: got pending=%0d busy=%b, expected 0",
                     src0.size() + src1.size() + exp_q.size(), busy_o);
        end
        foreach (log_q[i]) if (log_q[i].we && log_q[i].addr == A_TXDATA) n_wr++;
        checks++;
        if (n_wr != 24) begin
            errors++;
            $display("FAIL random_count: got %0d, expected 24", n_wr);
        end
    endtask

    task automatic test_reset_mid();
        int k = 0;
        log_q.delete();
        @(negedge clk);
        busy_left = 1000;
        src0.push_back(8'h3C);
        do begin
            @(posedge clk);
            #1;
            k++;
        end while (!(m_rsp_ready_o && busy_o && log_q.size() >= 1) && k < 50);
        checks++;
        if (!(m_rsp_ready_o && busy_o)) begin
            errors++;
            $display("FAIL reset_mid_reach: got rsp_ready=%b, expected 1", m_rsp_ready_o);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({m_req_valid_o, m_we_o, m_sel_o, m_addr_o, m_data_o, m_rsp_ready_o,
             req0_ready_o, req1_ready_o, busy_o} !== '0) begin
            errors++;
            $display("FAIL reset_mid_outputs: got valid=%b rsp_ready=%b busy=%b, expected 0",
                     m_req_valid_o, m_rsp_ready_o, busy_o);
        end
        busy_left = 0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        log_q.delete();
        rst_n = 1'b1;
        check_init("reinit");
        repeat (20) @(posedge clk);
        #1;
        checks++;
        if (log_q.size() != INIT_N || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_dropped: got txns=%0d busy=%b, expected txns=%0d busy=0",
                     log_q.size(), busy_o, INIT_N);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_busy_poll();
        test_back_to_back();
        test_stall();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
        $fatal(1, "watchdog expired");
    end

endmodule
